// File: rtl/md_unit.sv
`default_nettype none
// md_unit: multi-cycle MIPS multiply/divide unit owning HI/LO, rev 1.0.
// Optional MADD/MADDU accumulate operations are built when MD_MADD_EN is defined.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  state_t      state, state_next;
  logic [4:0]  count;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        accept, finish, long_op;

`ifdef MD_MADD_EN
  assign long_op = ~Op[2] | (Op[2:1] == 2'b11);
`else
  assign long_op = ~Op[2];
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (Start && long_op) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (count <= 5'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign finish = (state == RUN) && (count <= 5'd1);
  assign Busy   = (state == RUN);

  // Even opcodes (MULT, DIV, MADD) are the signed variants.
  logic        signed_op, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, product, result;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;

  assign signed_op = ~op_q[0];
  assign a_neg     = signed_op & a_q[31];
  assign b_neg     = signed_op & b_q[31];
  assign a_ext     = {{32{a_neg}}, a_q};
  assign b_ext     = {{32{b_neg}}, b_q};
  // Low 64 bits of an extended 64x64 product equal the true signed/unsigned product.
  assign product   = a_ext * b_ext;

  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign b_div = (b_q == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;

  always_comb begin
    result = {HI, LO};
    case (op_q)
      OP_MULT, OP_MULTU: result = product;
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0)
          result = {a_q, 32'hFFFF_FFFF};
        else
          result = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: result = {HI, LO} + product;
`endif
      default: result = {HI, LO};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= 5'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      if (accept) begin
        op_q  <= Op;
        a_q   <= A;
        b_q   <= B;
        count <= (Op[2:1] == 2'b01) ? DIV_LOAD : MULT_LOAD;
      end else if (state == RUN) begin
        count <= count - 5'd1;
      end

      if (finish)
        {HI, LO} <= result;
      else if (state == IDLE && Start && Op == OP_MTHI)
        HI <= A;
      else if (state == IDLE && Start && Op == OP_MTLO)
        LO <= A;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// tb_md_unit: scoreboard bench for md_unit (MULT/DIV/MT*, reset abort, optional MADD).
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  md_unit dut (
    .Clk(clk), .Reset(rst), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    e.n = 5;
    r   = {mhi, mlo};
    case (o)
      3'd0: r = 64'(sx * sy);
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        e.n = 10;
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        e.n = 10;
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
      3'd6: r = {mhi, mlo} + 64'(sx * sy);
      3'd7: r = {mhi, mlo} + {32'd0, x} * {32'd0, y};
      default: r = {mhi, mlo};
    endcase
    e.hi = r[63:32];
    e.lo = r[31:0];
    return e;
  endfunction

  // Monitor: measures each Busy pulse and scores the result visible when it drops.
  int   bcnt = 0;
  logic prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt = 0;
      prev = 1'b0;
    end else if (busy === 1'b1) begin
      bcnt++;
      prev = 1'b1;
    end else begin
      if (prev && sb.size() > 0) begin
        e = sb.pop_front();
        check("busy_len", 64'(bcnt), 64'(e.n));
        check("hi", {32'd0, hi}, {32'd0, e.hi});
        check("lo", {32'd0, lo}, {32'd0, e.lo});
      end
      prev = 1'b0;
      bcnt = 0;
    end
  end

  // Called at negedge+1; returns at negedge+1 of the first busy cycle.
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(o, x, y);
    sb.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x;
    @(negedge clk); #1;
    start = 1'b0;
    if (o == 3'd4) mhi = x;
    else           mlo = x;
    check("mt_busy", {63'd0, busy}, 64'd0);
    check("mt_hi", {32'd0, hi}, {32'd0, mhi});
    check("mt_lo", {32'd0, lo}, {32'd0, mlo});
  endtask

  initial begin
    logic [1:0] sel;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;

    start_op(3'd0, 32'hFFFF_FFFE, 32'd3);          wait_done("mult");
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);          wait_done("div");
    start_op(3'd3, 32'd7, 32'd0);                  wait_done("divu0");
    start_op(3'd2, 32'd5, 32'd0);                  wait_done("div0");
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done("divovf");
    start_op(3'd2, 32'd7, 32'hFFFF_FFFE);          wait_done("divneg");
    for (int i = 0; i < 8; i++) begin
      sel = 2'($urandom_range(0, 3));
      start_op({1'b0, sel}, $urandom, $urandom);
      wait_done("rand");
    end

    mt(3'd4, 32'hDEAD_BEEF);
    mt(3'd5, 32'hCAFE_F00D);

    // MTHI issued in the third busy cycle must be ignored.
    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) begin @(negedge clk); #1; end
    start = 1'b1; op = 3'd4; a = 32'd1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("multu_mthi");

    // Reset in the fourth busy cycle aborts the divide.
    start_op(3'd2, 32'd100, 32'd7);
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    sb.delete();
    mhi = 32'd0;
    mlo = 32'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    mt(3'd5, 32'h0000_1234);

    mt(3'd4, 32'd0);
    mt(3'd5, 32'd10);
`ifdef MD_MADD_EN
    start_op(3'd6, 32'd4, 32'd5);                  wait_done("madd");
    start_op(3'd6, 32'hFFFF_FFFF, 32'd1);          wait_done("madd_neg");
    start_op(3'd7, 32'hFFFF_FFFF, 32'd2);          wait_done("maddu");
`else
    for (int k = 6; k < 8; k++) begin
      start = 1'b1; op = 3'(k); a = 32'd4; b = 32'd5;
      @(negedge clk); #1;
      start = 1'b0;
      check("madd_off_busy", {63'd0, busy}, 64'd0);
      repeat (6) begin @(negedge clk); #1; end
      check("madd_off_busy2", {63'd0, busy}, 64'd0);
      check("madd_off_hi", {32'd0, hi}, {32'd0, mhi});
      check("madd_off_lo", {32'd0, lo}, {32'd0, mlo});
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
